// File: rtl/mmio_timer.sv
// 64-bit machine timer (mtime/mtimecmp/ctrl) with an AXI4-Lite slave port and a level interrupt.
// Latency: read and write responses are valid the cycle after the address/data handshake; irq lags its condition by 1 cycle.
// Backpressure: one outstanding read and one outstanding write; awready/wready/arready stay low until bready/rready drain the response.
// Ports: clk/rst (async, active-high); AXI4-Lite write (aw*, w*, b*) and read (ar*, r*) channels; irq = IE & (mtime >= mtimecmp).
module mmio_timer #(
   parameter int ADDR_WIDTH = 12,
   parameter int PRESCALE   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [31:0]           wdata,
   input  logic [3:0]            wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [31:0]           rdata,
   output logic [1:0]            rresp,
   output logic                  rvalid,
   input  logic                  rready,
   output logic                  irq
);

   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam logic [1:0]  RESP_SLVERR  = 2'b10;
   localparam logic [2:0]  IDX_MTIME_LO = 3'd0;
   localparam logic [2:0]  IDX_MTIME_HI = 3'd1;
   localparam logic [2:0]  IDX_CMP_LO   = 3'd2;
   localparam logic [2:0]  IDX_CMP_HI   = 3'd3;
   localparam logic [2:0]  IDX_CTRL     = 3'd4;
   localparam logic [15:0] PS_LAST      = 16'(PRESCALE - 1);

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t    w_state, w_next;
   r_state_t    r_state, r_next;

   logic [2:0]  w_idx, r_idx;
   logic        w_fire, r_fire;
   logic        wr_mtime_lo, wr_mtime_hi;

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        ctrl_en, ctrl_ie;
   logic [15:0] ps_cnt;
   logic [31:0] shadow_hi;
   logic [31:0] rd_val;

   // Only bits [4:2] select a register; the rest of the address is don't-care.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:5], awaddr[1:0],
                               araddr[ADDR_WIDTH-1:5], araddr[1:0]};

   assign w_idx  = awaddr[4:2];
   assign r_idx  = araddr[4:2];
   assign w_fire = awready & awvalid & wvalid;
   assign r_fire = arready & arvalid;

   function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

   // ---------------- write FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) w_state <= W_IDLE;
      else     w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (awvalid && wvalid) w_next = W_RESP;
         W_RESP:  if (bready)            w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // Address and data are only taken together, so the ready is gated by both valids.
   always_comb begin
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = !rst && awvalid && wvalid;
            wready  = !rst && awvalid && wvalid;
         end
         W_RESP:  bvalid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         bresp <= RESP_OKAY;
      else if (w_fire) bresp <= (w_idx > IDX_CTRL) ? RESP_SLVERR : RESP_OKAY;
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (arvalid) r_next = R_DATA;
         R_DATA:  if (rready)  r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      arready = 1'b0;
      rvalid  = 1'b0;
      case (r_state)
         R_IDLE:  arready = !rst;
         R_DATA:  rvalid  = 1'b1;
         default: ;
      endcase
   end

   // ---------------- timer state ----------------
   // An all-zero strobe is a no-op, so it must not disturb the prescale phase either.
   assign wr_mtime_lo = w_fire && (w_idx == IDX_MTIME_LO) && (wstrb != 4'b0000);
   assign wr_mtime_hi = w_fire && (w_idx == IDX_MTIME_HI) && (wstrb != 4'b0000);

   // A software write to mtime replaces any increment due this cycle and restarts the prescale phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime  <= 64'd0;
         ps_cnt <= 16'd0;
      end else if (wr_mtime_lo || wr_mtime_hi) begin
         mtime[31:0]  <= wr_mtime_lo ? lane_merge(mtime[31:0],  wdata, wstrb) : mtime[31:0];
         mtime[63:32] <= wr_mtime_hi ? lane_merge(mtime[63:32], wdata, wstrb) : mtime[63:32];
         ps_cnt       <= 16'd0;
      end else if (!ctrl_en) begin
         ps_cnt <= 16'd0;
      end else if (ps_cnt == PS_LAST) begin
         mtime  <= mtime + 64'd1;
         ps_cnt <= 16'd0;
      end else begin
         ps_cnt <= ps_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtimecmp <= '1;
         ctrl_en  <= 1'b0;
         ctrl_ie  <= 1'b0;
      end else if (w_fire) begin
         if (w_idx == IDX_CMP_LO) mtimecmp[31:0]  <= lane_merge(mtimecmp[31:0],  wdata, wstrb);
         if (w_idx == IDX_CMP_HI) mtimecmp[63:32] <= lane_merge(mtimecmp[63:32], wdata, wstrb);
         if (w_idx == IDX_CTRL && wstrb[0]) begin
            ctrl_en <= wdata[0];
            ctrl_ie <= wdata[1];
         end
      end
   end

   // ---------------- read data ----------------
   always_comb begin
      rd_val = 32'd0;
      case (r_idx)
         IDX_MTIME_LO: rd_val = mtime[31:0];
         IDX_MTIME_HI: rd_val = shadow_hi;
         IDX_CMP_LO:   rd_val = mtimecmp[31:0];
         IDX_CMP_HI:   rd_val = mtimecmp[63:32];
         IDX_CTRL:     rd_val = {30'd0, ctrl_ie, ctrl_en};
         default:      rd_val = 32'd0;
      endcase
   end

   // Values are sampled before this edge's writes land, so a same-cycle read sees the old contents.
   // Reading MTIME_LO freezes the upper word so the following MTIME_HI read cannot tear across a carry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata     <= 32'd0;
         rresp     <= RESP_OKAY;
         shadow_hi <= 32'd0;
      end else if (r_fire) begin
         rdata <= rd_val;
         rresp <= (r_idx > IDX_CTRL) ? RESP_SLVERR : RESP_OKAY;
         if (r_idx == IDX_MTIME_LO) shadow_hi <= mtime[63:32];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq <= 1'b0;
      else     irq <= ctrl_ie & (mtime >= mtimecmp);
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Randomized bench for mmio_timer: two instances (prescale 1 and 3) share one AXI4-Lite master.
// Expected values come from a closed-form timer model: mtime = base + (cycles since epoch) / PRESCALE.
// Summary line reports the number of comparisons and failures.
module tb_mmio_timer;

   localparam int AW = 12;
   localparam int P0 = 1;
   localparam int P1 = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] awaddr = '0;
   logic          awvalid = 1'b0;
   logic [31:0]   wdata = '0;
   logic [3:0]    wstrb = '0;
   logic          wvalid = 1'b0;
   logic          bready = 1'b0;
   logic [AW-1:0] araddr = '0;
   logic          arvalid = 1'b0;
   logic          rready = 1'b0;

   logic [1:0]       awready, wready, bvalid, arready, rvalid, irq;
   logic [1:0][1:0]  bresp, rresp;
   logic [1:0][31:0] rdata;

   mmio_timer #(.ADDR_WIDTH(AW), .PRESCALE(P0)) dut0 (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready[0]),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready[0]),
      .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready[0]),
      .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready),
      .irq(irq[0])
   );

   mmio_timer #(.ADDR_WIDTH(AW), .PRESCALE(P1)) dut1 (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready[1]),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready[1]),
      .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready[1]),
      .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready),
      .irq(irq[1])
   );

   // cyc == number of rising edges seen so far (valid when sampled between edges)
   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          pval [2] = '{P0, P1};
   logic [63:0] m_base [2];
   longint      m_k0 [2];
   bit          m_en [2];
   bit          m_ie [2];
   logic [63:0] m_cmp [2];
   logic [31:0] m_shadow [2];
   longint      last_kw;

   function automatic logic [63:0] mtime_at(input int i, input longint k);
      if (!m_en[i]) return m_base[i];
      return m_base[i] + 64'((k - m_k0[i]) / longint'(pval[i]));
   endfunction

   function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic bit exp_irq(input int i, input longint k);
      return m_ie[i] && (mtime_at(i, k - 1) >= m_cmp[i]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_base[i] = 64'd0; m_k0[i] = 0; m_en[i] = 1'b0; m_ie[i] = 1'b0;
         m_cmp[i] = '1; m_shadow[i] = 32'd0;
      end
   endtask

   // Effect of a write accepted at edge kw.
   task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input longint kw);
      logic [63:0] old;
      for (int i = 0; i < 2; i++) begin
         case (a[4:2])
            3'd0: if (s != 0) begin
               old = mtime_at(i, kw - 1);
               m_base[i] = {old[63:32], lanes(old[31:0], d, s)};
               m_k0[i] = kw;
            end
            3'd1: if (s != 0) begin
               old = mtime_at(i, kw - 1);
               m_base[i] = {lanes(old[63:32], d, s), old[31:0]};
               m_k0[i] = kw;
            end
            3'd2: m_cmp[i][31:0]  = lanes(m_cmp[i][31:0], d, s);
            3'd3: m_cmp[i][63:32] = lanes(m_cmp[i][63:32], d, s);
            3'd4: if (s[0]) begin
               if (d[0] != m_en[i]) begin
                  m_base[i] = mtime_at(i, kw);
                  m_k0[i] = kw;
                  m_en[i] = d[0];
               end
               m_ie[i] = d[1];
            end
            default: ;
         endcase
      end
   endtask

   // Value returned by a read accepted at edge kr (sees state from before that edge).
   task automatic model_read(input int i, input logic [2:0] idx, input longint kr,
                             output logic [31:0] v, output logic [1:0] r);
      logic [63:0] mt;
      v = 32'd0;
      r = 2'b00;
      case (idx)
         3'd0: begin mt = mtime_at(i, kr - 1); m_shadow[i] = mt[63:32]; v = mt[31:0]; end
         3'd1: v = m_shadow[i];
         3'd2: v = m_cmp[i][31:0];
         3'd3: v = m_cmp[i][63:32];
         3'd4: v = {30'd0, m_ie[i], m_en[i]};
         default: r = 2'b10;
      endcase
   endtask

   // ---------------- bus tasks (entered/left at posedge+1) ----------------
   task automatic do_reset();
      rst = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) check_val($sformatf("irq%0d", i), irq[i], exp_irq(i, cyc));
      end
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int hold);
      logic [1:0] er;
      awaddr = a[AW-1:0]; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      #1;
      check_val("awready_accept", awready, 2'b11);
      check_val("wready_accept", wready, 2'b11);
      @(posedge clk); #1;
      last_kw = cyc;
      awvalid = 1'b0; wvalid = 1'b0;
      model_write(a, d, s, last_kw);
      er = (a[4:2] > 3'd4) ? 2'b10 : 2'b00;
      for (int h = 0; h < hold; h++) begin
         check_val("bvalid_hold", bvalid, 2'b11);
         check_val("bresp_hold", bresp, {er, er});
         awvalid = 1'b1; wvalid = 1'b1;
         #1 check_val("awready_blocked", awready, 2'b00);
         @(posedge clk); #1;
         awvalid = 1'b0; wvalid = 1'b0;
      end
      check_val("bvalid", bvalid, 2'b11);
      check_val("bresp", bresp, {er, er});
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      check_val("bvalid_drop", bvalid, 2'b00);
   endtask

   task automatic axi_read(input logic [31:0] a, input int hold);
      longint kr;
      logic [31:0] ev [2];
      logic [1:0]  er [2];
      araddr = a[AW-1:0]; arvalid = 1'b1; rready = 1'b0;
      #1 check_val("arready_accept", arready, 2'b11);
      @(posedge clk); #1;
      kr = cyc;
      arvalid = 1'b0;
      for (int i = 0; i < 2; i++) model_read(i, a[4:2], kr, ev[i], er[i]);
      for (int h = 0; h <= hold; h++) begin
         check_val("rvalid", rvalid, 2'b11);
         for (int i = 0; i < 2; i++) begin
            check_val($sformatf("rdata%0d_a%0h", i, a[4:0]), rdata[i], ev[i]);
            check_val($sformatf("rresp%0d", i), rresp[i], er[i]);
         end
         if (h < hold) begin
            arvalid = 1'b1;
            #1 check_val("arready_blocked", arready, 2'b00);
            @(posedge clk); #1;
            arvalid = 1'b0;
         end
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      check_val("rvalid_drop", rvalid, 2'b00);
   endtask

   // Read and write of the same register accepted on the same edge.
   task automatic rw_same(input logic [31:0] a, input logic [31:0] d);
      longint k;
      logic [31:0] ev [2];
      logic [1:0]  er [2];
      awaddr = a[AW-1:0]; araddr = a[AW-1:0]; wdata = d; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(posedge clk); #1;
      k = cyc;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 2; i++) model_read(i, a[4:2], k, ev[i], er[i]);
      model_write(a, d, 4'hF, k);
      check_val("rw_bvalid", bvalid, 2'b11);
      check_val("rw_rvalid", rvalid, 2'b11);
      for (int i = 0; i < 2; i++) check_val($sformatf("rw_rdata%0d", i), rdata[i], ev[i]);
      bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0; rready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      longint rise [2];
      logic [31:0] a, d;
      logic [3:0]  s;
      int idx;

      // reset state, with all valids high to show nothing is accepted
      model_reset();
      #2 rst = 1'b1;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_awready", awready, 2'b00);
      check_val("rst_wready", wready, 2'b00);
      check_val("rst_arready", arready, 2'b00);
      check_val("rst_bvalid", bvalid, 2'b00);
      check_val("rst_rvalid", rvalid, 2'b00);
      check_val("rst_bresp", bresp, 4'd0);
      check_val("rst_rresp", rresp, 4'd0);
      check_val("rst_rdata", rdata, 64'd0);
      check_val("rst_irq", irq, 2'b00);
      do_reset();
      for (int r = 0; r < 5; r++) axi_read(32'(r * 4), 0);

      // partial strobe into MTIMECMP_LO -> 0xFFFF_CCFF
      axi_write(32'h08, 32'hAABB_CCDD, 4'b0010, 0);
      axi_read(32'h08, 0);
      check_val("strb_cmp_lo", rdata[0], 32'hFFFF_CCFF);

      // unmapped offsets
      axi_read(32'h18, 0);
      axi_write(32'h14, 32'h1234_5678, 4'hF, 0);
      axi_write(32'h0C, 32'h0, 4'h0, 0);
      for (int r = 0; r < 5; r++) axi_read(32'(r * 4), 0);

      // held responses
      axi_write(32'h0C, 32'h0000_0001, 4'hF, 5);
      axi_read(32'h0C, 5);

      // irq rises one cycle after mtime reaches 10
      do_reset();
      axi_write(32'h08, 32'd10, 4'hF, 0);
      axi_write(32'h0C, 32'd0, 4'hF, 0);
      axi_write(32'h10, 32'h3, 4'hF, 0);
      rise[0] = -1; rise[1] = -1;
      for (int c = 0; c < 50; c++) begin
         idle(1);
         for (int i = 0; i < 2; i++) if (irq[i] && rise[i] < 0) rise[i] = cyc;
      end
      check_val("irq_rise_p1", rise[0], last_kw + 11);
      check_val("irq_rise_p3", rise[1], last_kw + 31);

      // tear-free 64-bit read across the low-word carry
      do_reset();
      axi_write(32'h00, 32'hFFFF_FFFF, 4'hF, 0);
      axi_write(32'h04, 32'h0, 4'hF, 0);
      axi_write(32'h10, 32'h1, 4'hF, 0);
      idle($urandom_range(0, 3));
      axi_read(32'h00, 0);
      axi_read(32'h04, 0);
      axi_write(32'h00, 32'hFFFF_FFF0, 4'hF, 0);
      axi_read(32'h00, 0);
      axi_read(32'h04, 0);

      // reset while a write response is pending
      awaddr = 12'h008; wdata = 32'd5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      check_val("pend_bvalid", bvalid, 2'b11);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      #1;
      check_val("abort_bvalid", bvalid, 2'b00);
      check_val("abort_irq", irq, 2'b00);
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check_val("abort_no_resp", bvalid, 2'b00);
      end
      bready = 1'b1;
      @(posedge clk); #1 bready = 1'b0;
      axi_read(32'h08, 0);
      axi_read(32'h0C, 0);
      idle(2);

      // randomized traffic
      for (int n = 0; n < 250; n++) begin
         idx = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
         a = ($urandom & 32'hFE0) | 32'(idx << 2) | ($urandom & 32'h3);
         d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 64));
         if (idx == 4) d = 32'($urandom_range(0, 3));
         s = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15));
         case ($urandom_range(0, 9))
            0:       rw_same(a, d);
            1, 2, 3, 4: axi_write(a, d, s, $urandom_range(0, 3));
            default: axi_read(a, $urandom_range(0, 3));
         endcase
         idle($urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule
